fp_rnd_arbiter: RTL
===================

# fp_rnd_arbiter

Two-source collector placed directly upstream of the FPU rounding stage. It buffers pre-rounding results (`fp_rnd_in_type`) from the pipelined FMA unit and the iterative divide/sqrt unit. It arbitrates between them round-robin and presents a single registered valid/ready stream, tagged with destination, to the rounder. This removes the structural hazard when both units finish in the same cycle.

## Interface
- `DEPTH`, 2: entries per source FIFO (power of two, ≥2)
- `TAG_W`, 5: width of the destination tag carried with each result
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `flush_i`  in  1  synchronous kill of all buffered and output results
- `fma_valid_i`  in  1  FMA result valid
- `fma_ready_o`  out  1  FMA FIFO not full
- `fma_data_i`  in  $bits(fp_rnd_in_type)=85  FMA pre-rounding result
- `fma_tag_i`  in  TAG_W  FMA destination tag
- `div_valid_i`  in  1  FDIV/FSQRT result valid
- `div_ready_o`  out  1  DIV FIFO not full
- `div_data_i`  in  85  DIV pre-rounding result
- `div_tag_i`  in  TAG_W  DIV destination tag
- `rnd_valid_o`  out  1  output register holds a result
- `rnd_ready_i`  in  1  rounding stage accepts
- `rnd_data_o`  out  85  selected `fp_rnd_in_type`
- `rnd_tag_o`  out  TAG_W  selected tag
- `rnd_src_o`  out  1  0 = FMA, 1 = DIV
- `fma_cnt_o`, `div_cnt_o`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Each source has its own FIFO. It pushes on `valid_i && ready_o`. `ready_o = (cnt != DEPTH)`, which is purely registered and has no combinational path from `rnd_ready_i`.
- The FIFO stores `{data, tag}`. Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Count is one bit wider.
- The output register (`rnd_valid_o`, data, tag, src) loads when `load = !rnd_valid_o || rnd_ready_i`, and at least one FIFO is non-empty.
- Arbitration:
  - If only one FIFO is non-empty, it is selected.
  - If both are non-empty, the source selected is the one not granted last.
  - The last-grant flag `last_src` updates only on a load. Its reset value is 1, so FMA wins the first tie.
- A pop from the selected FIFO occurs in the same cycle as the load.
- If `rnd_valid_o && rnd_ready_i` and no FIFO is non-empty, `rnd_valid_o` clears.
- A push and a pop on the same FIFO in the same cycle leaves the count unchanged. This is legal when full: `ready_o` is low, so no push happens. It is also legal when empty: a push to an empty FIFO is not visible to the arbiter until the next cycle.
- `flush_i` takes priority over everything:
  - both FIFOs' pointers and counts are cleared
  - `rnd_valid_o` is cleared
  - concurrent pushes are dropped
  - `last_src` is kept
- Payload is never modified; the block is transparent to `fp_rnd_in_type` contents.

## Timing
- Reset values (asynchronous, `rst_n` = 0):
  - `rnd_valid_o` = 0, `rnd_data_o` = 0, `rnd_tag_o` = 0, `rnd_src_o` = 0
  - both counts = 0, so `fma_ready_o` = `div_ready_o` = 1
  - `last_src` = 1
- Reset deassertion mid-transfer: all in-flight results are lost. Sources must be reset together.
- Latency: a push at edge N gives `rnd_valid_o` = 1 after edge N+1 when the output is free. There is no bypass, so minimum latency is 2 cycles.
- Throughput: one result per cycle when `rnd_ready_i` stays high.
- Output stability: while `rnd_valid_o && !rnd_ready_i`, data, tag and src are held stable.
- Input handshake: a source may hold `valid_i` across cycles. Each cycle in which `valid_i && ready_o` counts as a distinct push.
- Occupancy: per FIFO, occupancy never exceeds DEPTH. Total buffered results ≤ 2·DEPTH + 1.

## Test plan
- **Reset:** apply `rst_n` = 0 mid-traffic → next cycle `rnd_valid_o` = 0, counts = 0, both readies = 1, and the first tie after release grants FMA.
- **Single-source latency:** push FMA tag 3 at edge 0 with `rnd_ready_i` = 1 → `rnd_valid_o` = 1, tag = 3, src = 0 after edge 1, then low after edge 2.
- **Simultaneous completion:** push FMA tags 1, 2 and DIV tags 10, 11 in the same two cycles → output order is 1, 10, 2, 11.
- **Backpressure:** hold `rnd_ready_i` = 0 and push 3 FMA results with DEPTH = 2 → `fma_ready_o` = 0 after the third accepted push (1 in the output register plus 2 in the FIFO). The fourth push is not accepted and the output holds constant. On release, results drain in order.
- **Flush:** with both FIFOs full and the output valid, assert `flush_i` together with an FMA push → the next cycle shows all counts 0, `rnd_valid_o` = 0, and the pushed result never appears.
- **Wrap-around:** stream 20 DIV results with random `rnd_ready_i` → the tag sequence matches the input order exactly, with no loss or duplication.

Source files
------------

// File: rtl/fp_rnd_arbiter_if.sv
// Pre-rounding payload type and the collector's handshake bundle.
// Two result sources in, one tagged stream out to the rounder.
package fp_rnd_pkg;
  typedef struct packed {
    logic        sign;
    logic [13:0] expo;
    logic [59:0] mant;
    logic [2:0]  rm;
    logic [4:0]  flags;
    logic [1:0]  fmt;
  } fp_rnd_in_type;
endpackage

interface fp_rnd_arbiter_if #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
);
  import fp_rnd_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush_i;
  logic             fma_valid_i;
  logic             fma_ready_o;
  fp_rnd_in_type    fma_data_i;
  logic [TAG_W-1:0] fma_tag_i;
  logic             div_valid_i;
  logic             div_ready_o;
  fp_rnd_in_type    div_data_i;
  logic [TAG_W-1:0] div_tag_i;
  logic             rnd_valid_o;
  logic             rnd_ready_i;
  fp_rnd_in_type    rnd_data_o;
  logic [TAG_W-1:0] rnd_tag_o;
  logic             rnd_src_o;
  logic [CW-1:0]    fma_cnt_o;
  logic [CW-1:0]    div_cnt_o;

  modport master (
    output flush_i,
    output fma_valid_i, fma_data_i, fma_tag_i,
    output div_valid_i, div_data_i, div_tag_i,
    output rnd_ready_i,
    input  fma_ready_o, div_ready_o,
    input  rnd_valid_o, rnd_data_o,
    input  rnd_tag_o, rnd_src_o,
    input  fma_cnt_o, div_cnt_o
  );

  modport slave (
    input  flush_i,
    input  fma_valid_i, fma_data_i, fma_tag_i,
    input  div_valid_i, div_data_i, div_tag_i,
    input  rnd_ready_i,
    output fma_ready_o, div_ready_o,
    output rnd_valid_o, rnd_data_o,
    output rnd_tag_o, rnd_src_o,
    output fma_cnt_o, div_cnt_o
  );
endinterface

// File: rtl/fp_rnd_arbiter.sv
// Round-robin collector of FMA and DIV/SQRT results ahead of the rounder.
// Per-source FIFOs feed one registered output slot.
module fp_rnd_arbiter
  import fp_rnd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  fp_rnd_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $bits(fp_rnd_in_type);
  localparam int EW = DW + TAG_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] mem [2][DEPTH];
  logic [AW-1:0] wp  [2];
  logic [AW-1:0] rp  [2];
  logic [CW-1:0] cnt [2];
  logic [EW-1:0] ent [2];
  logic [EW-1:0] head [2];

  logic [1:0] vin;
  logic [1:0] ne;
  logic [1:0] rdy;
  logic [1:0] push;
  logic [1:0] pop;
  logic       sel;
  logic       load;
  logic       last_src;

  logic             rnd_valid;
  logic [DW-1:0]    rnd_data;
  logic [TAG_W-1:0] rnd_tag;
  logic             rnd_src;

  assign vin[0] = bus.fma_valid_i;
  assign vin[1] = bus.div_valid_i;
  assign ent[0] = {bus.fma_data_i, bus.fma_tag_i};
  assign ent[1] = {bus.div_data_i, bus.div_tag_i};

  always_comb begin
    ne   = '0;
    rdy  = '0;
    push = '0;
    pop  = '0;
    for (int s = 0; s < 2; s++) begin
      ne[s]   = cnt[s] != '0;
      rdy[s]  = cnt[s] != FULL;
      push[s] = vin[s] && rdy[s] && !bus.flush_i;
      head[s] = mem[s][rp[s]];
    end
    // on a tie, grant whichever source lost last time
    sel    = ne[1] && (!ne[0] || !last_src);
    load   = (!rnd_valid || bus.rnd_ready_i)
          && (ne[0] || ne[1]);
    pop[0] = load && !sel;
    pop[1] = load && sel;
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wp[s]] <= ent[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        wp[s]  <= '0;
        rp[s]  <= '0;
        cnt[s] <= '0;
      end
    end else if (bus.flush_i) begin
      for (int s = 0; s < 2; s++) begin
        wp[s]  <= '0;
        rp[s]  <= '0;
        cnt[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wp[s] <= wp[s] + AW'(1);
        if (pop[s])  rp[s] <= rp[s] + AW'(1);
        cnt[s] <= cnt[s] + CW'(push[s])
                - CW'(pop[s]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      rnd_tag   <= '0;
      rnd_src   <= 1'b0;
      last_src  <= 1'b1;
    end else if (bus.flush_i) begin
      rnd_valid <= 1'b0;
    end else if (load) begin
      rnd_valid <= 1'b1;
      rnd_data  <= sel ? head[1][EW-1:TAG_W]
                       : head[0][EW-1:TAG_W];
      rnd_tag   <= sel ? head[1][TAG_W-1:0]
                       : head[0][TAG_W-1:0];
      rnd_src   <= sel;
      last_src  <= sel;
    end else if (bus.rnd_ready_i) begin
      rnd_valid <= 1'b0;
    end
  end

  assign bus.fma_ready_o = rdy[0];
  assign bus.div_ready_o = rdy[1];
  assign bus.fma_cnt_o   = cnt[0];
  assign bus.div_cnt_o   = cnt[1];
  assign bus.rnd_valid_o = rnd_valid;
  assign bus.rnd_data_o  = fp_rnd_in_type'(rnd_data);
  assign bus.rnd_tag_o   = rnd_tag;
  assign bus.rnd_src_o   = rnd_src;
endmodule
